// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions in the
// status word, the buffered entry layout and default geometry.
package alu_pkg;

  localparam int RA_W_DEFAULT  = 4;
  localparam int DEPTH_DEFAULT = 2;

  // Bit positions of the architectural flags inside a 16-bit status word.
  localparam int FLAG_Z = 15;
  localparam int FLAG_N = 14;
  localparam int FLAG_C = 13;
  localparam int FLAG_V = 12;

  // One buffered ALU result; flags are kept in Z,N,C,V order (msb first).
  typedef struct packed {
    logic [15:0]             result;
    logic [3:0]              flags;
    logic [RA_W_DEFAULT-1:0] rd;
    logic                    rd_we;
    logic                    flag_we;
  } entry_t;

  // Pull the four architectural flags out of a raw ALU status word.
  function automatic logic [3:0] status_flags(input logic [15:0] status);
    return {status[FLAG_Z], status[FLAG_N], status[FLAG_C], status[FLAG_V]};
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry strict-FIFO store for ALU results. Exposes the head entry for
// write-back and the second (newer) slot so the top level can forward from
// either buffered result.
module result_fifo2
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_req,
  input  entry_t din,
  output logic   ready,
  input  logic   pop_req,
  output logic   valid,
  output entry_t head,
  output entry_t newer,
  output logic   newer_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic             head_ptr;
  logic             tail_ptr;
  entry_t           mem [2];
  logic             push;
  logic             pop;

  // Full buffer never accepts, even when it is being drained this cycle.
  assign ready = count < CNT_W'(DEPTH);
  assign valid = count != '0;
  assign push  = push_req && ready;
  assign pop   = valid && pop_req;

  assign head        = mem[head_ptr];
  assign newer       = mem[~head_ptr];
  assign newer_valid = count == CNT_W'(DEPTH);

  // Occupancy and pointer bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
    end else begin
      if (push) tail_ptr <= ~tail_ptr;
      if (pop)  head_ptr <= ~head_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  // NOTE: the storage array has no reset; every consumer qualifies it with
  // count, so stale contents are never observable and the flops stay cheap.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= din;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: buffers results in a 2-entry FIFO,
// drains them to the register-file write port over valid/ready, owns the
// architectural status register and a saturating commit counter.
// Optional feature: define ALU_BYPASS_EN to build the forwarding lookup;
// otherwise byp_hit/byp_data are constant 0 and byp_addr is ignored.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int RA_W  = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_result,
  input  logic [15:0]     in_status,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_rd_we,
  input  logic            in_flag_we,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [15:0]     wb_data,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_we,
  output logic [15:0]     status_reg,
  output logic [15:0]     commit_cnt,
  input  logic [RA_W-1:0] byp_addr,
  output logic            byp_hit,
  output logic [15:0]     byp_data
);

  entry_t     din;
  entry_t     head;
  entry_t     newer;
  logic       newer_valid;
  logic       pop;
  logic [3:0] flags;
  logic       unused_status;

  assign din.result  = in_result;
  assign din.flags   = status_flags(in_status);
  assign din.rd      = in_rd;
  assign din.rd_we   = in_rd_we;
  assign din.flag_we = in_flag_we;

  // Only bits 15:12 of the ALU status word carry meaning.
  assign unused_status = &{1'b0, in_status[11:0]};

  result_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_req    (in_valid),
    .din         (din),
    .ready       (in_ready),
    .pop_req     (wb_ready),
    .valid       (wb_valid),
    .head        (head),
    .newer       (newer),
    .newer_valid (newer_valid)
  );

  assign pop = wb_valid && wb_ready;

  // Write-back port is forced to zero while the buffer is empty.
  assign wb_data = wb_valid ? head.result : '0;
  assign wb_rd   = wb_valid ? head.rd     : '0;
  assign wb_we   = wb_valid && head.rd_we;

  assign status_reg = {flags, 12'h000};

  // Architectural flags and commit counter advance on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= '0;
      commit_cnt <= '0;
    end else if (pop) begin
      if (head.flag_we) flags <= head.flags;
      if (commit_cnt != 16'hFFFF) commit_cnt <= commit_cnt + 16'd1;
    end
  end

`ifdef ALU_BYPASS_EN
  logic unused_byp;

  assign unused_byp = &{1'b0, newer.flags, newer.flag_we};

  // Forwarding lookup: newest matching buffered result wins.
  // NOTE: outputs get a default first so no path through the block leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (wb_valid && head.rd_we && (head.rd == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = head.result;
    end
    if (newer_valid && newer.rd_we && (newer.rd == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = newer.result;
    end
  end
`else
  logic unused_byp;

  assign unused_byp = &{1'b0, byp_addr, newer, newer_valid};
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the driver pushes each accepted
// entry into an expected queue, a negedge monitor compares the write-back
// port, status register, commit counter and forwarding outputs against a
// queue-based reference model.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [15:0] in_status;
  logic [3:0]  in_rd;
  logic        in_rd_we;
  logic        in_flag_we;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [15:0] status_reg;
  logic [15:0] commit_cnt;
  logic [3:0]  byp_addr;
  logic        byp_hit;
  logic [15:0] byp_data;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  rd;
    logic        rwe;
    logic        fwe;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  exp_flags;
  logic [15:0] exp_cnt;
  int          n_cmp;
  int          n_err;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_status  (in_status),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_flag_we (in_flag_we),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .status_reg (status_reg),
    .commit_cnt (commit_cnt),
    .byp_addr   (byp_addr),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; record the entry if the DUT accepts it.
  task automatic step(input logic v, input logic [15:0] res, input logic [15:0] st,
                      input logic [3:0] rd, input logic rwe, input logic fwe,
                      input logic rdy, input logic [3:0] ba);
    logic acc;
    exp_t e;
    in_valid   = v;
    in_result  = res;
    in_status  = st;
    in_rd      = rd;
    in_rd_we   = rwe;
    in_flag_we = fwe;
    wb_ready   = rdy;
    byp_addr   = ba;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      e.res = res;
      e.fl  = st[15:12];
      e.rd  = rd;
      e.rwe = rwe;
      e.fwe = fwe;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare outputs against the model, then retire a popped entry.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        h;
    logic [15:0] d;
    if (!rst_n) begin
      exp_q.delete();
      exp_flags = '0;
      exp_cnt   = '0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("wb_valid", 32'(wb_valid), 32'(exp_q.size() > 0));
      check("status_reg", 32'(status_reg), 32'({exp_flags, 12'h000}));
      check("commit_cnt", 32'(commit_cnt), 32'(exp_cnt));
      if (exp_q.size() > 0) begin
        check("wb_data", 32'(wb_data), 32'(exp_q[0].res));
        check("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
        check("wb_we", 32'(wb_we), 32'(exp_q[0].rwe));
      end else begin
        check("wb_idle", 32'({wb_data, wb_rd, wb_we}), 32'd0);
      end
      h = 1'b0;
      d = '0;
`ifdef ALU_BYPASS_EN
      foreach (exp_q[i]) begin
        if (exp_q[i].rwe && exp_q[i].rd == byp_addr) begin
          h = 1'b1;
          d = exp_q[i].res;
        end
      end
`endif
      check("byp_hit", 32'(byp_hit), 32'(h));
      check("byp_data", 32'(byp_data), 32'(d));
      if (wb_valid && wb_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.fwe) exp_flags = e.fl;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  initial begin
    logic exp_byp;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_result  = '0;
    in_status  = '0;
    in_rd      = '0;
    in_rd_we   = 1'b0;
    in_flag_we = 1'b0;
    wb_ready   = 1'b0;
    byp_addr   = '0;
`ifdef ALU_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb", 32'({wb_valid, wb_data, wb_rd, wb_we}), 32'd0);
    check("rst_status", 32'(status_reg), 32'd0);
    check("rst_commit", 32'(commit_cnt), 32'd0);
    check("rst_byp", 32'({byp_hit, byp_data}), 32'd0);
    rst_n = 1'b1;

    // Single entry: visible next cycle, flags land the cycle after the pop.
    step(1'b1, 16'h1234, 16'h8000, 4'd3, 1'b1, 1'b1, 1'b1, 4'd0);
    #1;
    check("single_valid", 32'(wb_valid), 32'd1);
    check("single_data", 32'(wb_data), 32'h1234);
    check("single_rd", 32'(wb_rd), 32'd3);
    step(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    #1;
    check("single_status", 32'(status_reg), 32'h8000);
    check("single_commit", 32'(commit_cnt), 32'd1);

    // Back-pressure: fill, try a third push, then drain in order.
    step(1'b1, 16'h0001, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 16'h0002, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h0003, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 16'h0003, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    #1;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second", 32'(wb_data), 32'h0002);
    step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    #1;
    check("bp_empty", 32'(wb_valid), 32'd0);

    // Flag masking: flag_we=0 entry leaves the status register alone.
    step(1'b1, 16'h0055, 16'h4000, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 16'h0066, 16'hF000, 4'd2, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    check("mask_status", 32'(status_reg), 32'h4000);

    // Forwarding: two entries for r5, newest wins.
    step(1'b1, 16'h00AA, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5);
    step(1'b1, 16'h00BB, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5);
    #1;
    check("byp5_hit", 32'(byp_hit), 32'(exp_byp));
    check("byp5_data", 32'(byp_data), exp_byp ? 32'h00BB : 32'd0);
    byp_addr = 4'd6;
    #1;
    check("byp6_hit", 32'(byp_hit), 32'd0);

    // Asynchronous reset between edges with a full buffer.
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_status", 32'(status_reg), 32'd0);
    check("arst_commit", 32'(commit_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Steady push+pop at occupancy 1 for 10 cycles.
    step(1'b1, 16'h0100, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h0101 + 16'(i), 16'h0000, 4'd7, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    check("pp_commit", 32'(commit_cnt), 32'd10);
    check("pp_valid", 32'(wb_valid), 32'd1);
    check("pp_head", 32'(wb_data), 32'h010A);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)));

    // Drain everything and confirm nothing was lost.
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Pipeline stage directly downstream of the 16-bit ALU. Captures each ALU result and its status word together with the destination register tag in a 2-entry buffer. Drains the buffer to the register-file write port through a valid/ready handshake. Owns the architectural status register (Z,N,C,V in bits 15:12), updating it when a flag-writing entry commits.

## Interface
- DEPTH, 2: buffer entries; only 2 supported.
- RA_W, 4: register address width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU output entry is valid.
- in_ready  out  1  stage accepts an entry this cycle.
- in_result  in  16  ALU result.
- in_status  in  16  ALU status word; bits 15:12 = Z,N,C,V, bits 11:0 ignored.
- in_rd  in  RA_W  destination register.
- in_rd_we  in  1  entry writes the register file.
- in_flag_we  in  1  entry updates the status register.
- wb_valid  out  1  head entry presented to the register file.
- wb_ready  in  1  register file accepts head entry.
- wb_data  out  16  head result.
- wb_rd  out  RA_W  head destination.
- wb_we  out  1  head in_rd_we copy.
- status_reg  out  16  architectural flags in bits 15:12; bits 11:0 always 0.
- commit_cnt  out  16  count of committed entries, saturating.
- byp_addr  in  RA_W  forwarding lookup address.
- byp_hit  out  1  a buffered entry targets byp_addr.
- byp_data  out  16  newest matching buffered result.

## Operation
- Push when in_valid && in_ready. Pop when wb_valid && wb_ready.
- in_ready = (count < 2). The signal is combinational from registered count and does not depend on wb_ready, so a full buffer never accepts, even if a pop occurs that same cycle.
- wb_valid = (count > 0). wb_* come from the head entry. wb_data, wb_rd and wb_we are 0 when the buffer is empty.
- Simultaneous push and pop at count 1: the head leaves, the new entry becomes head, and count stays 1.
- At count 0, a pushed entry is not visible on wb_* until the next cycle; there is no flow-through.
- On pop with flag_we=1: status_reg[15:12] <= entry flags. With flag_we=0, status_reg is unchanged.
- Entries with rd_we=0 still pop through the handshake, with wb_we=0.
- On every pop, commit_cnt increments. It saturates at 16'hFFFF.
- Entry order is strict FIFO. Entries are never dropped or reordered.
- in_* are sampled only on the push edge. in_* values while in_ready=0 are ignored.

## Timing
- Reset values: count=0, in_ready=1, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, status_reg=0, commit_cnt=0, byp_hit=0, byp_data=0.
- Latency: 1 cycle from push edge to wb_valid. Throughput is 1 entry/cycle in steady state.
- status_reg changes on the cycle after the pop edge, i.e. it is registered.
- Reset asserted mid-operation empties the buffer immediately and clears status_reg and commit_cnt. All buffered entries are lost.
- The bypass path is combinational from buffer registers and byp_addr. It never sees an entry in its push cycle.

## Configuration
- ALU_BYPASS_EN defined: the bypass lookup is active. Valid entries with rd_we=1 and rd==byp_addr are searched newest first. byp_hit=1 and byp_data is set to that entry's result.
- ALU_BYPASS_EN undefined: byp_hit and byp_data are tied to 0, and no comparators are built. byp_addr remains a port and is ignored.

## Structure
- Shared package alu_pkg holds:
  - flag index constants FLAG_Z=15, FLAG_N=14, FLAG_C=13, FLAG_V=12;
  - the entry typedef (result, flags[3:0], rd, rd_we, flag_we);
  - RA_W and DEPTH defaults.
- Sub-module result_fifo2: the 2-entry storage with head/tail pointer, count, push/pop, and read-out of both slots for the bypass. The top level holds the status register, commit_cnt and the bypass mux.

## Test plan
- Single entry: push result=16'h1234, rd=3, rd_we=1, flag_we=1, status=16'h8000, with wb_ready=1. Required response: the next cycle shows wb_valid=1, wb_data=16'h1234, wb_rd=3. The cycle after the pop shows status_reg=16'h8000 and commit_cnt=1.
- Back-pressure: hold wb_ready=0 and push A=16'h0001 and B=16'h0002. Required response: in_ready=0 after two pushes, and a third in_valid is not accepted. Then release wb_ready: A pops, then B, in order. in_ready returns to 1 after the first pop.
- Flag masking: pop an entry with flag_we=0 and status 16'hF000 while status_reg=16'h4000. Required response: status_reg stays 16'h4000, and lower 12 bits are always 0.
- Async reset: assert rst_n=0 between clock edges with count=2. Required response: immediately wb_valid=0, in_ready=1, status_reg=0, commit_cnt=0.
- Bypass (ALU_BYPASS_EN): buffer holds rd=5 with 16'h00AA (older) and rd=5 with 16'h00BB (newer), with byp_addr=5. Required response: byp_hit=1, byp_data=16'h00BB. Setting byp_addr=6 gives byp_hit=0. Without the macro, byp_hit=0 in both cases.
- Simultaneous push/pop at count=1 for 10 cycles. Required response: count stays 1, results appear in order, and commit_cnt=10.
